sprite_draw_scheduler: RTL and testbench

//  Frame-rate scheduler sharing the single VGA framebuffer write port between N sprite/bullet

---
 rtl/sprite_draw_scheduler.sv | 173 +++++++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_draw_scheduler.sv
// Purpose: frame-rate scheduler sharing one VGA framebuffer write port between N drawing engines.
// Latency: engine x/y/color/wren reach the VGA port combinationally (zero cycles) while granted.
// Backpressure: one engine at a time via start/done; ticks arriving mid-pass are dropped and flagged.
module sprite_draw_scheduler #(
  parameter int N_CLIENTS = 4,
  parameter int FRAME_DIV = 833333,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_CLIENTS-1:0]   enable_mask,
  input  logic [N_CLIENTS-1:0]   cl_done,
  input  logic [8*N_CLIENTS-1:0] cl_x,
  input  logic [7*N_CLIENTS-1:0] cl_y,
  input  logic [3*N_CLIENTS-1:0] cl_color,
  input  logic [N_CLIENTS-1:0]   cl_wren,
  output logic [N_CLIENTS-1:0]   cl_start,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_color,
  output logic                   vga_wren,
  output logic                   frame_tick,
  output logic                   busy,
  output logic                   overrun,
  output logic [N_CLIENTS-1:0]   timeout_err
);

  localparam int CNT_W = 20;
  localparam int TMO_W = 8;
  localparam int SEL_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_START,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [N_CLIENTS-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [N_CLIENTS-1:0]   start_q, start_d;
  logic                   overrun_q, overrun_d;
  logic [N_CLIENTS-1:0]   terr_q, terr_d;

  // One-hot of the selected engine; all zero once sel has run past the last engine.
  logic [N_CLIENTS-1:0]   sel_oh;
  logic                   mask_sel;
  logic                   done_sel;
  logic                   grant;

  assign sel_oh   = N_CLIENTS'(1) << sel_q;
  assign mask_sel = |(mask_q & sel_oh);
  assign done_sel = |(cl_done & sel_oh);
  assign grant    = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_RELEASE);

  assign frame_tick  = (cnt_q == CNT_W'(FRAME_DIV - 1));
  // Busy covers the cycle in which the tick is accepted, so an empty pass spans N+2 cycles.
  assign busy        = (state_q != S_IDLE) || frame_tick;
  assign cl_start    = start_q;
  assign overrun     = overrun_q;
  assign timeout_err = terr_q;

  // Free-running frame divider, wraps at FRAME_DIV-1.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (frame_tick) begin
      cnt_d = '0;
    end
  end

  // Scheduler next-state: walk engines in ascending order, one start/done handshake each.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    mask_d    = mask_q;
    tmo_d     = tmo_q;
    start_d   = start_q;
    terr_d    = terr_q;
    // A tick seen outside IDLE is dropped; only the sticky flag remembers it.
    overrun_d = overrun_q | (frame_tick && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          mask_d  = enable_mask;
          sel_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (sel_q == SEL_W'(N_CLIENTS)) begin
          state_d = S_IDLE;
        end else if (mask_sel) begin
          state_d = S_START;
        end else begin
          sel_d = sel_q + SEL_W'(1);
        end
      end
      S_START: begin
        start_d = sel_oh;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_sel) begin
          start_d = '0;
          state_d = S_RELEASE;
        end else if (tmo_q == TMO_W'(TIMEOUT)) begin
          start_d = '0;
          terr_d  = terr_q | sel_oh;
          state_d = S_RELEASE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RELEASE: begin
        // No timeout here: an engine that never drops done stalls the scheduler.
        if (!done_sel) begin
          sel_d   = sel_q + SEL_W'(1);
          state_d = S_SCAN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Granted-engine mux to the VGA adapter; non-granted writes are discarded.
  always_comb begin
    vga_x     = '0;
    vga_y     = '0;
    vga_color = '0;
    vga_wren  = 1'b0;
    if (grant) begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (sel_oh[i]) begin
          vga_x     = cl_x[8*i +: 8];
          vga_y     = cl_y[7*i +: 7];
          vga_color = cl_color[3*i +: 3];
          vga_wren  = cl_wren[i];
        end
      end
    end
  end

  // State registers; async reset drops starts and grant immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      start_q   <= '0;
      overrun_q <= 1'b0;
      terr_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      start_q   <= start_d;
      overrun_q <= overrun_d;
      terr_q    <= terr_d;
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Purpose: directed bench for sprite_draw_scheduler with behavioural drawing engines.
// Latency: expectations are hand-derived cycle counts from each frame tick.
// Backpressure: engines model normal, never-done and long-held-done behaviour.
module tb_sprite_draw_scheduler;

  localparam int N = 4;

  logic           clk;
  logic           resetn;
  logic [N-1:0]   enable_mask;
  logic [N-1:0]   cl_done;
  logic [8*N-1:0] cl_x;
  logic [7*N-1:0] cl_y;
  logic [3*N-1:0] cl_color;
  logic [N-1:0]   cl_wren;
  logic [N-1:0]   cl_start;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_color;
  logic           vga_wren;
  logic           frame_tick;
  logic           busy;
  logic           overrun;
  logic [N-1:0]   timeout_err;

  sprite_draw_scheduler #(.N_CLIENTS(N), .FRAME_DIV(100), .TIMEOUT(10)) dut (
    .clk(clk), .resetn(resetn), .enable_mask(enable_mask), .cl_done(cl_done),
    .cl_x(cl_x), .cl_y(cl_y), .cl_color(cl_color), .cl_wren(cl_wren),
    .cl_start(cl_start), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
    .vga_wren(vga_wren), .frame_tick(frame_tick), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine configuration driven by the stimulus.
  logic [7:0] x_arr [N];
  logic [6:0] y_arr [N];
  logic [2:0] c_arr [N];
  logic       w_arr [N];
  logic       never_arr [N];
  int         hold_arr [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cl_x[8*i +: 8]     = x_arr[i];
      cl_y[7*i +: 7]     = y_arr[i];
      cl_color[3*i +: 3] = c_arr[i];
      cl_wren[i]         = w_arr[i];
    end
  end

  // Behavioural engines: done 3 cycles after start, dropped hold_arr cycles after start falls.
  int scnt [N];
  int rel  [N];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cl_done <= '0;
      for (int i = 0; i < N; i++) begin
        scnt[i] <= 0;
        rel[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cl_start[i]) begin
          rel[i]  <= 0;
          scnt[i] <= scnt[i] + 1;
          if (scnt[i] == 2 && !never_arr[i]) cl_done[i] <= 1'b1;
        end else begin
          scnt[i] <= 0;
          if (cl_done[i]) begin
            rel[i] <= rel[i] + 1;
            if (rel[i] + 1 >= hold_arr[i]) cl_done[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Monitor: start order log, start-high cycle counts, VGA mux consistency.
  int   start_log [$];
  int   hi_cnt [N];
  int   mux_bad;
  int   wren_cnt;
  int   x50_cnt;
  logic [N-1:0] prev_start;
  initial prev_start = '0;
  always @(negedge clk) begin
    if (resetn) begin
      for (int i = 0; i < N; i++) begin
        if (cl_start[i] && !prev_start[i]) start_log.push_back(i);
        if (cl_start[i]) begin
          hi_cnt[i] = hi_cnt[i] + 1;
          if (vga_wren !== w_arr[i] || vga_x !== x_arr[i]) mux_bad = mux_bad + 1;
        end
      end
      if (!busy && vga_wren) mux_bad = mux_bad + 1;
      if (vga_wren) wren_cnt = wren_cnt + 1;
      if (vga_x == 8'd50) x50_cnt = x50_cnt + 1;
    end
    prev_start = cl_start;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    start_log.delete();
    for (int i = 0; i < N; i++) hi_cnt[i] = 0;
    mux_bad  = 0;
    wren_cnt = 0;
    x50_cnt  = 0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Returns at the negedge of the tick cycle; an expired bound counts as a failure.
  task automatic wait_tick(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic check_log(input string tag, input int exp_q [$]);
    check({tag, "_n"}, start_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < start_log.size(); i++)
      check({tag, "_ord"}, start_log[i], exp_q[i]);
  endtask

  task automatic set_engines_default();
    for (int i = 0; i < N; i++) begin
      x_arr[i] = 8'(10 + i);
      y_arr[i] = 7'(20 + i);
      c_arr[i] = 3'(i);
      w_arr[i] = 1'b1;
      never_arr[i] = 1'b0;
      hold_arr[i]  = 1;
    end
  endtask

  initial begin
    int n;
    logic seen;
    set_engines_default();
    clear_mon();
    enable_mask = '0;
    resetn = 1'b0;
    cycles(3);

    // Reset state.
    check("rst_start", cl_start, 0);
    check("rst_wren", vga_wren, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_ovr", overrun, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_vx", vga_x, 0);
    resetn = 1'b1;

    // 1: all engines, one start each in ascending order, mux follows grant.
    enable_mask = 4'b1111;
    wait_tick("t1_tick");
    clear_mon();
    cycles(95);
    check_log("t1", '{0, 1, 2, 3});
    check("t1_mux", mux_bad, 0);
    check("t1_h0", hi_cnt[0], 4);
    check("t1_terr", timeout_err, 0);

    // 2: sparse mask; ungranted engine 1 writing x=50 never reaches the port.
    enable_mask = 4'b0101;
    for (int i = 0; i < N; i++) begin
      w_arr[i] = 1'b0;
      x_arr[i] = 8'd0;
    end
    w_arr[1] = 1'b1;
    x_arr[1] = 8'd50;
    wait_tick("t2_tick");
    clear_mon();
    cycles(95);
    check_log("t2", '{0, 2});
    check("t2_wren", wren_cnt, 0);
    check("t2_x50", x50_cnt, 0);

    // 5: granted engine values appear on the VGA port in the same cycle.
    set_engines_default();
    x_arr[2] = 8'd159;
    y_arr[2] = 7'd119;
    c_arr[2] = 3'b101;
    enable_mask = 4'b0100;
    wait_tick("t5_tick");
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (cl_start[2]) seen = 1'b1;
    end
    check("t5_start", seen, 1);
    check("t5_vx", vga_x, 159);
    check("t5_vy", vga_y, 119);
    check("t5_vc", vga_color, 5);
    check("t5_vw", vga_wren, 1);
    #1 x_arr[2] = 8'd77;
    #1 check("t5_vx_comb", vga_x, 77);
    cycles(80);

    // All-zero mask: tick cycle plus N+1 SCAN cycles of busy, no starts.
    set_engines_default();
    enable_mask = 4'b0000;
    wait_tick("tz_tick");
    clear_mon();
    n = 0;
    for (int i = 0; i < 50 && busy; i++) begin
      n++;
      @(negedge clk);
    end
    check("tz_busy", n, 6);
    check("tz_starts", start_log.size(), 0);

    // 3: engine 1 never done -> 11 WAIT cycles of start, sticky error, 2 and 3 still run.
    enable_mask = 4'b1111;
    never_arr[1] = 1'b1;
    wait_tick("t3_tick");
    clear_mon();
    cycles(95);
    check("t3_h1", hi_cnt[1], 11);
    check("t3_terr", timeout_err, 4'b0010);
    check_log("t3", '{0, 1, 2, 3});
    never_arr[1] = 1'b0;

    // 4: engine 0 holds done for 150 cycles -> overrun at next tick, no restart meanwhile.
    enable_mask = 4'b0001;
    hold_arr[0] = 150;
    wait_tick("t4_tick");
    clear_mon();
    cycles(50);
    check("t4_ovr0", overrun, 0);
    cycles(60);
    check("t4_ovr1", overrun, 1);
    check("t4_busy", busy, 1);
    cycles(80);
    check("t4_starts", start_log.size(), 1);
    hold_arr[0] = 1;
    cycles(5);
    check("t4_restart", start_log.size(), 1);
    cycles(10);
    check("t4_restart2", start_log.size(), 2);

    // 6: async reset during WAIT of engine 3, then first start one tick after release.
    wait_tick("t6_sync");
    cycles(60);
    enable_mask = 4'b1000;
    never_arr[3] = 1'b1;
    wait_tick("t6_tick");
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (cl_start[3]) seen = 1'b1;
    end
    check("t6_start", seen, 1);
    cycles(3);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_start", cl_start, 0);
    check("t6_rst_wren", vga_wren, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_terr", timeout_err, 0);
    cycles(2);
    resetn = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (cl_start != 0) seen = 1'b1;
    end
    check("t6_first_start", n, 105);
    check("t6_which", cl_start, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
